lsu_bus: RTL
============

Name: lsu_bus

Overview:
- Parametrised successor of the single-cycle load-store unit. Takes one load/store request at a time from the core through a valid/ready handshake.
- Decodes the address into three regions:
  - data region, forwarded to an external memory controller over a req/ack bus with byte-lane masks;
  - output peripheral registers;
  - synchronised input registers.
- Adds sub-word store masking, misalignment/illegal-op/timeout error reporting, and a parametrised HEX count.
- Sits between the core's MEM stage and the SRAM controller / board I/O.

Parameters:
- DMEM_BASE, 32'h0000_2000: byte base of the data region; must be aligned to 2**DMEM_AW.
- DMEM_AW, 13: byte-address width of the data region. Hit when i_addr[31:DMEM_AW] == DMEM_BASE[31:DMEM_AW].
- NUM_HEX, 8: number of 7-seg digits, 1..8.
- BTN_W, 4: button input width, 1..8.
- TIMEOUT, 255: maximum cycles spent waiting for i_mem_ack; must be ≥1.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  1  request valid
- o_ready  out  1  request accepted when i_req & o_ready
- i_wren  in  1  1=store, 0=load
- i_func3  in  3  RISC-V funct3: size/sign
- i_addr  in  32  byte address
- i_st_data  in  32  store data, right-aligned
- o_done  out  1  one-cycle completion pulse
- o_ld_data  out  32  load result, valid with o_done
- o_err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal func3; valid with o_done
- o_mem_req  out  1  memory request, held until ack
- o_mem_we  out  1  memory write
- o_mem_addr  out  DMEM_AW  word-aligned offset; bits [1:0] = 0
- o_mem_wdata  out  32  lane-shifted store data
- o_mem_bmask  out  4  byte enables, 1 = active
- i_mem_ack  in  1  memory completion
- i_mem_rdata  in  32  read word, valid with ack
- i_io_sw  in  32  switches, asynchronous
- i_io_btn  in  BTN_W  buttons, asynchronous
- o_io_ledr, o_io_ledg, o_io_lcd  out  32 each
- o_io_hex  out  7*NUM_HEX  digit k in bits [7k+6:7k]

Behaviour:
- Reset: state IDLE; o_ready=1; every other output 0; all I/O registers and synchronisers 0.
- FSM states: IDLE, MEM, DONE.
  - IDLE: o_ready=1. On i_req, register addr/data/func3/wren at the edge. Go to MEM if the request is a legal data-region access, otherwise DONE.
  - MEM: o_mem_req=1; address, write data and mask held stable. On i_mem_ack, capture i_mem_rdata and go to DONE. If no ack arrives within TIMEOUT cycles, drop o_mem_req, set err=10, go to DONE. Ack in the first MEM cycle is legal.
  - DONE: o_done=1 for one cycle, then IDLE. o_ready=0 in MEM and DONE.
- Latency:
  - I/O, unmapped and error requests: o_done in cycle N+1 after acceptance in cycle N.
  - Data region: N+1+k, where k is the number of MEM cycles (k≥1).
- Address map:
  - Data region per DMEM_BASE/DMEM_AW.
  - Output region 0x7000–0x703F: LEDR 0x7000, LEDG 0x7010, HEX bytes 0x7020+k, LCD 0x7030.
  - Input region 0x7800–0x781F: SW 0x7800, BTN 0x7810.
  - Anything else is unmapped: loads return 0, stores are dropped, err=00.
- Size and alignment (func3[1:0], a = addr[1:0]):
  - byte: any a; mask = 1<<a.
  - half: a ∈ {0,2}; mask = 3<<a.
  - word: a = 0; mask = 4'hF.
  - Write data is replicated into the selected lane.
- Misaligned access: no bus or register side-effects; err=01.
- Illegal func3 (011, 110, 111, and 100/101 on stores): err=11; no side-effects.
- Load data: extract the lane selected by a, then zero-extend (func3[2]=1) or sign-extend. o_ld_data=0 whenever err≠00.
- Output registers:
  - Byte-lane writes apply at the edge ending the DONE cycle; o_io_* changes in cycle N+2.
  - HEX byte k stores bits [6:0]; bit 7 is read back as 0. Bytes at k ≥ NUM_HEX are not implemented and read 0.
  - Loads from the output region return the current register contents.
  - Unimplemented output addresses read 0 and ignore writes.
- Input registers:
  - i_io_sw and i_io_btn pass through 2-flop synchronisers; loads see the second stage.
  - BTN reads zero-extended to 32 bits. Stores to the input region are dropped.
- Reset mid-transaction: immediate IDLE, o_mem_req=0, no o_done for the aborted request.
- i_req while o_ready=0 is ignored; the core must hold the request.

Test Plan:
- Reset → o_ready=1, o_mem_req=0, o_io_ledr=0, o_io_hex=0.
- SW 32'hDEADBEEF, wait 2 cycles, lw 0x7800 → o_done at N+1, o_ld_data=DEADBEEF; lb 0x7803 → FFFFFFDE; lbu 0x7803 → 000000DE.
- sh data 0x0000ABCD to 0x2006 → o_mem_bmask=1100, o_mem_wdata=ABCDABCD, o_mem_addr=0x0004. Ack after 3 cycles → o_done in cycle N+4, err=00.
- lh 0x2003 → err=01, o_done at N+1, o_mem_req never asserted; sw 0x7002 → err=01, LEDR unchanged.
- lw 0x2000 with ack withheld → o_mem_req high for exactly 255 cycles, then o_done with err=10 and o_ld_data=0.
- sb 0x55 to 0x7021 with NUM_HEX=4 → o_io_hex[13:7]=7'h55 in cycle N+2. Assert reset during MEM → o_mem_req drops immediately and no o_done follows.

Source files
------------

// File: rtl/lsu_bus_if.sv
`default_nettype none
// ============================================================================
// lsu_bus_if : core request/response and memory-controller bus bundle
// Rev 1.0
// ============================================================================
interface lsu_bus_if #(
   parameter int DMEM_AW = 13
);
   // core side
   logic               i_req;
   logic               o_ready;
   logic               i_wren;
   logic [2:0]         i_func3;
   logic [31:0]        i_addr;
   logic [31:0]        i_st_data;
   logic               o_done;
   logic [31:0]        o_ld_data;
   logic [1:0]         o_err;
   // memory-controller side
   logic               o_mem_req;
   logic               o_mem_we;
   logic [DMEM_AW-1:0] o_mem_addr;
   logic [31:0]        o_mem_wdata;
   logic [3:0]         o_mem_bmask;
   logic               i_mem_ack;
   logic [31:0]        i_mem_rdata;

   modport slave (
      input  i_req, i_wren, i_func3, i_addr, i_st_data, i_mem_ack, i_mem_rdata,
      output o_ready, o_done, o_ld_data, o_err,
             o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask
   );

   modport master (
      output i_req, i_wren, i_func3, i_addr, i_st_data, i_mem_ack, i_mem_rdata,
      input  o_ready, o_done, o_ld_data, o_err,
             o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask
   );
endinterface
`default_nettype wire

// File: rtl/lsu_bus.sv
`default_nettype none
// ============================================================================
// lsu_bus : load/store unit routing core accesses to data memory, output
//           peripheral registers and synchronised input registers
// Rev 1.0
// ============================================================================
module lsu_bus #(
   parameter logic [31:0] DMEM_BASE = 32'h0000_2000,
   parameter int          DMEM_AW   = 13,
   parameter int          NUM_HEX   = 8,
   parameter int          BTN_W     = 4,
   parameter int          TIMEOUT   = 255
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   lsu_bus_if.slave             bus,
   input  logic [31:0]          i_io_sw,
   input  logic [BTN_W-1:0]     i_io_btn,
   output logic [31:0]          o_io_ledr,
   output logic [31:0]          o_io_ledg,
   output logic [31:0]          o_io_lcd,
   output logic [7*NUM_HEX-1:0] o_io_hex
);
   localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MEM  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ready_q, ready_d;
   logic                 done_q, done_d;
   logic [31:0]          ld_data_q, ld_data_d;
   logic [1:0]           err_q, err_d;
   logic                 mem_req_q, mem_req_d;
   logic                 mem_we_q, mem_we_d;
   logic [DMEM_AW-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]          mem_wdata_q, mem_wdata_d;
   logic [3:0]           mem_bmask_q, mem_bmask_d;
   logic [5:0]           addr_q, addr_d;
   logic [2:0]           func3_q, func3_d;
   logic                 wren_q, wren_d;
   logic                 out_wr_q, out_wr_d;
   logic [31:0]          wdata_q, wdata_d;
   logic [3:0]           bmask_q, bmask_d;
   logic [31:0]          ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
   logic [7*NUM_HEX-1:0] hex_q, hex_d;
   logic [31:0]          sw_s1_q, sw_s2_q;
   logic [BTN_W-1:0]     btn_s1_q, btn_s2_q;

   logic [1:0]  size, lane, dec_err;
   logic        illegal, misal, hit_mem, hit_out, hit_in;
   logic [3:0]  req_mask;
   logic [31:0] req_wdata, io_word;
   logic [63:0] hex_rd;
   logic [55:0] hex_pad, hex_pad_d;

   function automatic logic [31:0] ld_extract(input logic [31:0] word,
                                              input logic [1:0]  ln,
                                              input logic [2:0]  f3);
      logic [31:0] s;
      s = word >> {ln, 3'b000};
      case (f3[1:0])
         2'b00:   ld_extract = f3[2] ? {24'd0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
         2'b01:   ld_extract = f3[2] ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
         default: ld_extract = s;
      endcase
   endfunction

   // Request decode: size/alignment legality, region hit, lane mask and replicated data
   always_comb begin
      size    = bus.i_func3[1:0];
      lane    = bus.i_addr[1:0];
      illegal = (bus.i_func3 == 3'b011) || (bus.i_func3[2:1] == 2'b11) ||
                (bus.i_wren && bus.i_func3[2]);
      misal   = ((size == 2'b01) && lane[0]) || ((size == 2'b10) && (lane != 2'b00));
      dec_err = illegal ? 2'b11 : (misal ? 2'b01 : 2'b00);
      hit_mem = (bus.i_addr[31:DMEM_AW] == DMEM_BASE[31:DMEM_AW]);
      hit_out = (bus.i_addr[31:6] == 26'h00001C0);
      hit_in  = (bus.i_addr[31:5] == 27'h00003C0);
      case (size)
         2'b00: begin
            req_mask  = 4'b0001 << lane;
            req_wdata = {4{bus.i_st_data[7:0]}};
         end
         2'b01: begin
            req_mask  = 4'b0011 << lane;
            req_wdata = {2{bus.i_st_data[15:0]}};
         end
         default: begin
            req_mask  = 4'hF;
            req_wdata = bus.i_st_data;
         end
      endcase
   end

   // HEX digits padded to eight so every byte slot has a fixed position
   assign hex_pad = 56'(hex_q);
   assign hex_d   = hex_pad_d[7*NUM_HEX-1:0];

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         hex_rd[8*k +: 8] = {1'b0, hex_pad[7*k +: 7]};
      end
      io_word = '0;
      if (hit_out) begin
         case (bus.i_addr[5:2])
            4'h0:    io_word = ledr_q;
            4'h4:    io_word = ledg_q;
            4'h8:    io_word = hex_rd[31:0];
            4'h9:    io_word = hex_rd[63:32];
            4'hC:    io_word = lcd_q;
            default: io_word = '0;
         endcase
      end else if (hit_in) begin
         case (bus.i_addr[4:2])
            3'd0:    io_word = sw_s2_q;
            3'd4:    io_word = 32'(btn_s2_q);
            default: io_word = '0;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ready_d     = ready_q;
      done_d      = 1'b0;
      ld_data_d   = '0;
      err_d       = 2'b00;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_bmask_d = mem_bmask_q;
      addr_d      = addr_q;
      func3_d     = func3_q;
      wren_d      = wren_q;
      out_wr_d    = out_wr_q;
      wdata_d     = wdata_q;
      bmask_d     = bmask_q;
      ledr_d      = ledr_q;
      ledg_d      = ledg_q;
      lcd_d       = lcd_q;
      hex_pad_d   = hex_pad;
      case (state_q)
         S_IDLE: begin
            if (bus.i_req) begin
               addr_d   = bus.i_addr[5:0];
               func3_d  = bus.i_func3;
               wren_d   = bus.i_wren;
               wdata_d  = req_wdata;
               bmask_d  = req_mask;
               out_wr_d = bus.i_wren && (dec_err == 2'b00) && hit_out;
               ready_d  = 1'b0;
               if ((dec_err == 2'b00) && hit_mem) begin
                  state_d     = S_MEM;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.i_wren;
                  mem_addr_d  = {bus.i_addr[DMEM_AW-1:2], 2'b00};
                  mem_wdata_d = req_wdata;
                  mem_bmask_d = req_mask;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  err_d   = dec_err;
                  if ((dec_err == 2'b00) && !bus.i_wren) begin
                     ld_data_d = ld_extract(io_word, lane, bus.i_func3);
                  end
               end
            end
         end
         S_MEM: begin
            if (bus.i_mem_ack || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
               mem_bmask_d = '0;
               // an ack on the final allowed cycle still counts as success
               if (bus.i_mem_ack) begin
                  if (!wren_q) ld_data_d = ld_extract(bus.i_mem_rdata, addr_q[1:0], func3_q);
               end else begin
                  err_d = 2'b10;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d  = S_IDLE;
            ready_d  = 1'b1;
            out_wr_d = 1'b0;
            if (out_wr_q) begin
               for (int i = 0; i < 4; i++) begin
                  if (bmask_q[i]) begin
                     case (addr_q[5:2])
                        4'h0: ledr_d[8*i +: 8] = wdata_q[8*i +: 8];
                        4'h4: ledg_d[8*i +: 8] = wdata_q[8*i +: 8];
                        4'hC: lcd_d[8*i +: 8]  = wdata_q[8*i +: 8];
                        4'h8, 4'h9: hex_pad_d[7*(4*int'(addr_q[2]) + i) +: 7] = wdata_q[8*i +: 7];
                        default: ;
                     endcase
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ready_q     <= 1'b1;
         done_q      <= 1'b0;
         ld_data_q   <= '0;
         err_q       <= 2'b00;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_bmask_q <= '0;
         addr_q      <= '0;
         func3_q     <= '0;
         wren_q      <= 1'b0;
         out_wr_q    <= 1'b0;
         wdata_q     <= '0;
         bmask_q     <= '0;
         ledr_q      <= '0;
         ledg_q      <= '0;
         lcd_q       <= '0;
         hex_q       <= '0;
         sw_s1_q     <= '0;
         sw_s2_q     <= '0;
         btn_s1_q    <= '0;
         btn_s2_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ready_q     <= ready_d;
         done_q      <= done_d;
         ld_data_q   <= ld_data_d;
         err_q       <= err_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_bmask_q <= mem_bmask_d;
         addr_q      <= addr_d;
         func3_q     <= func3_d;
         wren_q      <= wren_d;
         out_wr_q    <= out_wr_d;
         wdata_q     <= wdata_d;
         bmask_q     <= bmask_d;
         ledr_q      <= ledr_d;
         ledg_q      <= ledg_d;
         lcd_q       <= lcd_d;
         hex_q       <= hex_d;
         sw_s1_q     <= i_io_sw;
         sw_s2_q     <= sw_s1_q;
         btn_s1_q    <= i_io_btn;
         btn_s2_q    <= btn_s1_q;
      end
   end

   assign bus.o_ready     = ready_q;
   assign bus.o_done      = done_q;
   assign bus.o_ld_data   = ld_data_q;
   assign bus.o_err       = err_q;
   assign bus.o_mem_req   = mem_req_q;
   assign bus.o_mem_we    = mem_we_q;
   assign bus.o_mem_addr  = mem_addr_q;
   assign bus.o_mem_wdata = mem_wdata_q;
   assign bus.o_mem_bmask = mem_bmask_q;
   assign o_io_ledr       = ledr_q;
   assign o_io_ledg       = ledg_q;
   assign o_io_lcd        = lcd_q;
   assign o_io_hex        = hex_q;
endmodule
`default_nettype wire
